// File: rtl/usb_rx_burst_sched_if.sv
// rtl/usb_rx_burst_sched_if.sv - buffer descriptor and TCQ request/confirm bundle
interface usb_rx_burst_sched_if #(
    parameter int LOCAL_ADDR_WIDTH = 17,
    parameter int DATA_BITS        = 3,
    parameter int REQUEST_LEN_BITS = 6,
    parameter int MEM_TAG          = 1,
    parameter int BUF_BITS         = 12
);
    localparam int AW = LOCAL_ADDR_WIDTH - DATA_BITS;

    logic                        s_buf_valid;
    logic                        s_buf_ready;
    logic [AW-1:0]               s_buf_addr;
    logic [BUF_BITS-1:0]         s_buf_beats;
    logic                        s_buf_trailer;

    logic                        m_tcq_valid;
    logic                        m_tcq_ready;
    logic [AW-1:0]               m_tcq_laddr;
    logic [REQUEST_LEN_BITS-1:0] m_tcq_length;
    logic [MEM_TAG-1:0]          m_tcq_tag;
    logic                        m_tcq_trailer;
    logic                        m_tcq_cvalid;
    logic                        m_tcq_cready;
    logic [MEM_TAG-1:0]          m_tcq_ctag;

    modport master (
        input  s_buf_valid, s_buf_addr, s_buf_beats, s_buf_trailer,
        output s_buf_ready,
        output m_tcq_valid, m_tcq_laddr, m_tcq_length, m_tcq_tag, m_tcq_trailer,
        input  m_tcq_ready,
        input  m_tcq_cvalid, m_tcq_ctag,
        output m_tcq_cready
    );

    modport slave (
        output s_buf_valid, s_buf_addr, s_buf_beats, s_buf_trailer,
        input  s_buf_ready,
        input  m_tcq_valid, m_tcq_laddr, m_tcq_length, m_tcq_tag, m_tcq_trailer,
        output m_tcq_ready,
        output m_tcq_cvalid, m_tcq_ctag,
        input  m_tcq_cready
    );
endinterface

// File: rtl/usb_rx_burst_sched.sv
// rtl/usb_rx_burst_sched.sv - splits RX buffers into aligned tagged RAM bursts
// and retires in-order confirmations, releasing each buffer when fully moved.
module usb_rx_burst_sched #(
    parameter int LOCAL_ADDR_WIDTH = 17,
    parameter int DATA_BITS        = 3,
    parameter int REQUEST_LEN_BITS = 6,
    parameter int MEM_TAG          = 1,
    parameter int BUF_BITS         = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_enable,
    usb_rx_burst_sched_if.master bus,
    output logic                 buf_release,
    output logic                 busy,
    output logic [15:0]          stat_bursts,
    output logic                 err_tag
);
    localparam int AW  = LOCAL_ADDR_WIDTH - DATA_BITS;
    localparam int RLB = REQUEST_LEN_BITS;
    localparam int NT  = 1 << MEM_TAG;
    localparam int RW  = BUF_BITS + 1;
    localparam int NW  = RLB + 1;
    localparam logic [MEM_TAG:0] SLOTS    = {1'b1, {MEM_TAG{1'b0}}};
    localparam logic [NW-1:0]    BURST_MAX = {1'b1, {RLB{1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic               trl_q, trl_d;
    logic               valid_q, valid_d;
    logic [AW-1:0]      laddr_q, laddr_d;
    logic [RLB-1:0]     len_q, len_d;
    logic [NW-1:0]      n_q, n_d;
    logic               rtrl_q, rtrl_d;
    logic [MEM_TAG-1:0] itag_q, itag_d;
    logic [MEM_TAG-1:0] etag_q, etag_d;
    logic [MEM_TAG:0]   outst_q, outst_d;
    logic [NT-1:0]      last_q, last_d;
    logic               rel_q, rel_d;
    logic [15:0]        stat_q, stat_d;
    logic               err_q, err_d;

    logic               cready, conf_fire, req_fire, slot_free, burst_last;
    logic [NW-1:0]      room;
    logic [RW-1:0]      room_ext, n_sel, n_minus, n_ext;

    always_comb begin
        cready    = (outst_q != '0);
        conf_fire = bus.m_tcq_cvalid & cready;
        req_fire  = valid_q & bus.m_tcq_ready;
        // A slot retiring this cycle may be reused immediately.
        slot_free = (outst_q < SLOTS) | conf_fire;

        // Beats left before the next burst-size boundary.
        room     = BURST_MAX - {1'b0, addr_q[RLB-1:0]};
        room_ext = RW'(room);
        n_sel    = (rem_q < room_ext) ? rem_q : room_ext;
        n_minus  = n_sel - RW'(1);
        n_ext    = RW'(n_q);
        burst_last = (rem_q == n_ext);

        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        trl_d   = trl_q;
        valid_d = valid_q;
        laddr_d = laddr_q;
        len_d   = len_q;
        n_d     = n_q;
        rtrl_d  = rtrl_q;
        itag_d  = itag_q;
        etag_d  = etag_q;
        last_d  = last_q;
        rel_d   = 1'b0;
        stat_d  = stat_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (ready_q && bus.s_buf_valid) begin
                    addr_d  = bus.s_buf_addr;
                    rem_d   = {1'b0, bus.s_buf_beats} + RW'(1);
                    trl_d   = bus.s_buf_trailer;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    laddr_d = addr_q;
                    len_d   = n_minus[RLB-1:0];
                    n_d     = n_sel[NW-1:0];
                    rtrl_d  = trl_q & (n_sel == rem_q);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (req_fire) begin
                    valid_d        = 1'b0;
                    rtrl_d         = 1'b0;
                    addr_d         = addr_q + AW'(n_q);
                    rem_d          = rem_q - n_ext;
                    itag_d         = itag_q + 1'b1;
                    last_d[itag_q] = burst_last;
                    state_d        = burst_last ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        case ({req_fire, conf_fire})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        if (conf_fire) begin
            etag_d = etag_q + 1'b1;
            stat_d = stat_q + 16'd1;
            rel_d  = last_q[etag_q];
            if (bus.m_tcq_ctag != etag_q) begin
                err_d = 1'b1;
            end
        end

        ready_d = (state_d == IDLE) & cfg_enable & (outst_d < SLOTS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            trl_q   <= 1'b0;
            valid_q <= 1'b0;
            laddr_q <= '0;
            len_q   <= '0;
            n_q     <= '0;
            rtrl_q  <= 1'b0;
            itag_q  <= '0;
            etag_q  <= '0;
            outst_q <= '0;
            last_q  <= '0;
            rel_q   <= 1'b0;
            stat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            trl_q   <= trl_d;
            valid_q <= valid_d;
            laddr_q <= laddr_d;
            len_q   <= len_d;
            n_q     <= n_d;
            rtrl_q  <= rtrl_d;
            itag_q  <= itag_d;
            etag_q  <= etag_d;
            outst_q <= outst_d;
            last_q  <= last_d;
            rel_q   <= rel_d;
            stat_q  <= stat_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_buf_ready   = ready_q;
    assign bus.m_tcq_valid   = valid_q;
    assign bus.m_tcq_laddr   = laddr_q;
    assign bus.m_tcq_length  = len_q;
    assign bus.m_tcq_tag     = itag_q;
    assign bus.m_tcq_trailer = rtrl_q;
    assign bus.m_tcq_cready  = cready;
    assign buf_release       = rel_q;
    assign busy              = (state_q != IDLE) | (outst_q != '0);
    assign stat_bursts       = stat_q;
    assign err_tag           = err_q;
endmodule
